// File: rtl/ratio_clk_bank.sv
// rtl/ratio_clk_bank.sv - multi-channel programmable-ratio divided clock bank
// Optional tick_o rising-edge strobes are built when RATIO_CLK_BANK_TICK_EN is defined.
module ratio_clk_bank #(
   parameter int CHANNELS  = 4,
   parameter int DIV_WIDTH = 8,
   parameter int DIV_RESET = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [CHANNELS-1:0]           en_i,
   input  logic [CHANNELS*DIV_WIDTH-1:0] div_i,
   input  logic [CHANNELS-1:0]           div_valid_i,
   output logic [CHANNELS-1:0]           div_ready_o,
   input  logic                          sync_i,
   output logic [CHANNELS-1:0]           ratio_clk_o
`ifdef RATIO_CLK_BANK_TICK_EN
   ,
   output logic [CHANNELS-1:0]           tick_o
`endif
);

   localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_RESET);
   localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);
   localparam logic [DIV_WIDTH:0]   ONE_X   = (DIV_WIDTH + 1)'(1);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [DIV_WIDTH-1:0] d_q, d_d;
      logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
      logic [DIV_WIDTH-1:0] pdiv_q, pdiv_d;
      logic                 pend_q, pend_d;
      logic                 out_q, out_d;
      logic                 en_q;
      logic [DIV_WIDTH:0]   h_d;
      logic                 stopped, wrap, xfer, apply;

      always_comb begin
         stopped = (d_q < TWO);
         wrap    = !stopped && (cnt_q == d_q - ONE);
         // xfer needs pend_q low and apply needs it high, so they never share an edge
         xfer    = div_valid_i[c] && !pend_q;
         apply   = pend_q && (wrap || sync_i || !en_i[c] || stopped);

         pdiv_d  = xfer ? div_i[c*DIV_WIDTH +: DIV_WIDTH] : pdiv_q;
         pend_d  = xfer || (pend_q && !apply);
         d_d     = apply ? pdiv_q : d_q;

         // en_q low on an enabled edge means a fresh start: begin a new high phase
         if (!en_i[c] || !en_q || apply || stopped || sync_i || wrap) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + ONE;
         end

         h_d   = ({1'b0, d_d} + ONE_X) >> 1;
         out_d = en_i[c] && (d_d >= TWO) && ({1'b0, cnt_d} < h_d);
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            d_q    <= DIV_RST;
            cnt_q  <= '0;
            pdiv_q <= DIV_RST;
            pend_q <= 1'b0;
            out_q  <= 1'b0;
            en_q   <= 1'b0;
         end else begin
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            out_q  <= out_d;
            en_q   <= en_i[c];
         end
      end

      assign ratio_clk_o[c] = out_q;
      assign div_ready_o[c] = ~pend_q;

`ifdef RATIO_CLK_BANK_TICK_EN
      logic tick_q, tick_d;

      always_comb begin
         tick_d = out_d && !out_q;
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            tick_q <= 1'b0;
         end else begin
            tick_q <= tick_d;
         end
      end

      assign tick_o[c] = tick_q;
`endif
   end

endmodule

// File: tb/tb_ratio_clk_bank.sv
// tb/tb_ratio_clk_bank.sv - directed self-checking bench for ratio_clk_bank
module tb_ratio_clk_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  en;
   logic [31:0] div;
   logic [3:0]  valid;
   logic [3:0]  ready;
   logic        sync;
   logic [3:0]  rclk;
`ifdef RATIO_CLK_BANK_TICK_EN
   logic [3:0]  tick;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ratio_clk_bank #(
      .CHANNELS (4),
      .DIV_WIDTH(8),
      .DIV_RESET(2)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en),
      .div_i      (div),
      .div_valid_i(valid),
      .div_ready_o(ready),
      .sync_i     (sync),
      .ratio_clk_o(rclk)
`ifdef RATIO_CLK_BANK_TICK_EN
      ,
      .tick_o     (tick)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Channel must already be disabled, so the value is applied on the following edge.
   task automatic set_div(input int ch, input int val);
      div[ch*8 +: 8] = val[7:0];
      valid[ch] = 1'b1;
      step();
      valid[ch] = 1'b0;
      check_eq("xfer_ready_low", {31'd0, ready[ch]}, 32'd0);
      step();
      check_eq("apply_ready_high", {31'd0, ready[ch]}, 32'd1);
   endtask

   task automatic check_pat(input string tag, input int ch, input string pat);
      for (int i = 0; i < pat.len(); i++) begin
         check_eq(tag, {31'd0, rclk[ch]}, (pat[i] == 8'h31) ? 32'd1 : 32'd0);
         step();
      end
   endtask

   initial begin
      string opat;
      string rpat;
      rst   = 1'b1;
      en    = 4'hf;
      valid = 4'h0;
      div   = '0;
      sync  = 1'b0;
      step();

      // reset state
      for (int i = 0; i < 3; i++) begin
         check_eq("rst_clk", {28'd0, rclk}, 32'h0);
         check_eq("rst_ready", {28'd0, ready}, 32'hf);
`ifdef RATIO_CLK_BANK_TICK_EN
         check_eq("rst_tick", {28'd0, tick}, 32'h0);
`endif
         step();
      end
      rst = 1'b0;
      step();
      check_pat("rst_release_d2", 0, "101010");

      // duty cycle D=5 then D=4
      en[1] = 1'b0;
      step();
      check_eq("dis_out", {31'd0, rclk[1]}, 32'd0);
      set_div(1, 5);
      en[1] = 1'b1;
      step();
      check_pat("duty5", 1, "1110011100");
      en[1] = 1'b0;
      step();
      set_div(1, 4);
      en[1] = 1'b1;
      step();
      check_pat("duty4", 1, "11001100");

      // boundary update: D=6 running, D=3 becomes pending while cnt=1
      en[2] = 1'b0;
      step();
      set_div(2, 6);
      en[2] = 1'b1;
      step();
      opat = "111000110110";
      rpat = "100000111111";
      for (int i = 0; i < 12; i++) begin
         check_eq("bnd_out", {31'd0, rclk[2]}, (opat[i] == 8'h31) ? 32'd1 : 32'd0);
         check_eq("bnd_ready", {31'd0, ready[2]}, (rpat[i] == 8'h31) ? 32'd1 : 32'd0);
         if (i == 0) begin
            div[16 +: 8] = 8'd3;
            valid[2] = 1'b1;
         end
         if (i == 1) div[16 +: 8] = 8'd7;
         if (i == 3) valid[2] = 1'b0;
         step();
      end

      // sync across misaligned channels
      en = 4'h0;
      step();
      set_div(0, 4);
      set_div(1, 6);
      set_div(2, 7);
      set_div(3, 9);
      en[0] = 1'b1;
      step();
      en[1] = 1'b1;
      step();
      step();
      en[2] = 1'b1;
      step();
      en[3] = 1'b1;
      repeat (3) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      check_eq("sync_k0", {28'd0, rclk}, 32'hf);
      step();
      check_eq("sync_k1", {28'd0, rclk}, 32'hf);
      step();
      check_eq("sync_k2", {28'd0, rclk}, 32'he);
      en[3] = 1'b0;
      step();
      check_eq("dis_mid_high", {28'd0, rclk}, 32'h4);

      // stopped divisor, then D=8 applied from the stopped state
      set_div(3, 1);
      en[3] = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         check_eq("stopped_out", {31'd0, rclk[3]}, 32'd0);
         step();
      end
      div[24 +: 8] = 8'd8;
      valid[3] = 1'b1;
      step();
      valid[3] = 1'b0;
      check_eq("d8_ready_low", {31'd0, ready[3]}, 32'd0);
      check_eq("d8_out_low", {31'd0, rclk[3]}, 32'd0);
      step();
      check_eq("d8_ready_high", {31'd0, ready[3]}, 32'd1);
      check_pat("d8_apply", 3, "11110000");
      en[3] = 1'b0;
      step();
      check_eq("d8_dis", {31'd0, rclk[3]}, 32'd0);
      en[3] = 1'b1;
      step();
      check_pat("d8_reen", 3, "1111000011110000");

`ifdef RATIO_CLK_BANK_TICK_EN
      en[1] = 1'b0;
      step();
      set_div(1, 5);
      en[1] = 1'b1;
      step();
      opat = "1110011100";
      rpat = "1000010000";
      for (int i = 0; i < 10; i++) begin
         check_eq("tick_out", {31'd0, rclk[1]}, (opat[i] == 8'h31) ? 32'd1 : 32'd0);
         check_eq("tick_pulse", {31'd0, tick[1]}, (rpat[i] == 8'h31) ? 32'd1 : 32'd0);
         step();
      end
`endif

      // reset mid-operation drops the pending D=3; channel returns to D=2
      div[8 +: 8] = 8'd3;
      valid[1] = 1'b1;
      step();
      valid[1] = 1'b0;
      check_eq("rstmid_pend", {31'd0, ready[1]}, 32'd0);
      rst = 1'b1;
      step();
      check_eq("rstmid_clk", {28'd0, rclk}, 32'h0);
      check_eq("rstmid_ready", {28'd0, ready}, 32'hf);
`ifdef RATIO_CLK_BANK_TICK_EN
      check_eq("rstmid_tick", {28'd0, tick}, 32'h0);
`endif
      rst = 1'b0;
      step();
      check_pat("rstmid_d2", 1, "101010");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
